// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder input conditioner: FSM states and defaults.
package encoder_pkg;

  localparam int ENC_CNT_W    = 16;
  localparam int ENC_DEF_FILT = 1000;
  localparam int CLK_HZ       = 100_000_000;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_LOW    = 3'd1,
    S_HIGH   = 3'd2,
    S_CHK_HI = 3'd3,
    S_CHK_LO = 3'd4
  } state_t;

  // Converts a filter time in ns into clk cycles, rounding down.
  function automatic int unsigned ns_to_cycles(input int unsigned ns);
    return (ns * (CLK_HZ / 1_000_000)) / 1000;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop synchroniser for a single asynchronous bit; all flops reset to 0.
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[N-2:0], d};
  end

  assign q = r_sync[N-1];

endmodule

// File: rtl/encoder_debounce.sv
// Encoder pin conditioner: synchronise, qualify each candidate edge for L_eff
// cycles, emit level + rise/fall strobes, count rejected candidates.
module encoder_debounce
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = ENC_CNT_W,
  parameter int DEF_FILT    = ENC_DEF_FILT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_raw,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             clear,
  output logic             enc_valid,
  output logic             enc_filt,
  output logic             enc_rise,
  output logic             enc_fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt,
  output state_t           dbg_state
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_valid;
  logic             r_filt;
  logic             r_rise;
  logic             r_fall;
  logic             r_glitch;
  logic [CNT_W-1:0] r_gcnt;

  logic             w_s_in;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_reject;

  bit_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (enc_raw),
    .q   (w_s_in)
  );

  assign w_len_eff = (filt_len == '0) ? CNT_W'(DEF_FILT) : filt_len;
  assign w_reject  = ((r_state == S_CHK_HI) && !w_s_in) ||
                     ((r_state == S_CHK_LO) &&  w_s_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_len    <= '0;
      r_valid  <= 1'b0;
      r_filt   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
      case (r_state)
        // Wait for the synchroniser to fill before trusting s_in.
        S_INIT: begin
          if (r_cnt == CNT_W'(SYNC_STAGES)) begin
            r_filt  <= w_s_in;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= w_s_in ? S_HIGH : S_LOW;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOW: begin
          if (w_s_in) begin
            r_len <= w_len_eff;
            if (w_len_eff == CNT_W'(1)) begin
              r_filt  <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_HIGH;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= S_CHK_HI;
            end
          end
        end
        S_HIGH: begin
          if (!w_s_in) begin
            r_len <= w_len_eff;
            if (w_len_eff == CNT_W'(1)) begin
              r_filt  <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_LOW;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= S_CHK_LO;
            end
          end
        end
        S_CHK_HI: begin
          if (w_s_in) begin
            if (r_cnt == r_len - CNT_W'(1)) begin
              r_filt  <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_HIGH;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_glitch <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_LOW;
          end
        end
        S_CHK_LO: begin
          if (!w_s_in) begin
            if (r_cnt == r_len - CNT_W'(1)) begin
              r_filt  <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_LOW;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_glitch <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_HIGH;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_INIT;
        end
      endcase
    end
  end

  // Clear has priority over a coincident reject; the count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_gcnt <= '0;
    else if (clear)                  r_gcnt <= '0;
    else if (w_reject && (r_gcnt != '1)) r_gcnt <= r_gcnt + CNT_W'(1);
  end

  assign enc_valid  = r_valid;
  assign enc_filt   = r_filt;
  assign enc_rise   = r_rise;
  assign enc_fall   = r_fall;
  assign glitch     = r_glitch;
  assign glitch_cnt = r_gcnt;
  assign dbg_state  = r_state;

endmodule
